// File: rtl/fetch_buffer_pkg.sv
// Shared core parameters for the fetch buffer: fetch geometry and core-wide widths.
package fetch_buffer_pkg;

  localparam int unsigned FETCH_WIDTH  = 4;
  localparam int unsigned INSTR_WIDTH  = 32;
  localparam int unsigned PACKET_WIDTH = FETCH_WIDTH * INSTR_WIDTH;

  localparam int unsigned WIDTH_PRD = 7;
  localparam int unsigned WIDTH_BRM = 4;
  localparam int unsigned WIDTH_TAG = 6;

endpackage

// File: rtl/fbuf_ram.sv
// Packet storage for the fetch buffer: one synchronous write port, one asynchronous read port.
module fbuf_ram #(
  parameter int unsigned WIDTH = 164,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  // Contents are intentionally left unreset; consumers gate the read data.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetch packets between fetch and decode, with flush and per-slot valid mask.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_we,
  input  logic [PACKET_WIDTH-1:0]   i_data4x,
  input  logic [WIDTH_ADDR-1:0]     i_pc,
  input  logic [FETCH_WIDTH-1:0]    i_imask,
  output logic                      o_full,
  input  logic                      i_re,
  output logic                      o_valid,
  output logic [PACKET_WIDTH-1:0]   o_data4x,
  output logic [WIDTH_ADDR-1:0]     o_pc,
  output logic [FETCH_WIDTH-1:0]    o_imask,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = PACKET_WIDTH + WIDTH_ADDR + FETCH_WIDTH;

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full, valid, enq, deq;
  logic [EntryW-1:0] wr_entry, rd_entry;

  assign full  = (count_q == CntW'(DEPTH));
  assign valid = (count_q != '0);

  // Full is checked on registered state, so a same-cycle dequeue never frees a slot for enqueue.
  assign enq = i_we & ~full & (|i_imask) & ~i_flush;
  assign deq = i_re & valid & ~i_flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign wr_entry = {i_data4x, i_pc, i_imask};

  fbuf_ram #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (enq),
    .i_waddr (tail_q),
    .i_wdata (wr_entry),
    .i_raddr (head_q),
    .o_rdata (rd_entry)
  );

  always_comb begin
    o_data4x = '0;
    o_pc     = '0;
    o_imask  = '0;
    if (valid) begin
      {o_data4x, o_pc, o_imask} = rd_entry;
    end
  end

  assign o_full  = full;
  assign o_valid = valid;
  assign o_count = count_q;

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: WIDTH_ADDR, default 32, PC width.
REQ-002 Parameter: DEPTH, default 8, packet entries; power of two, at least 2.
REQ-003 Port: i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_flush  input  1  kill all buffered packets (branch mispredict / redirect).
REQ-006 Port: i_we  input  1  enqueue request from fetch.
REQ-007 Port: i_data4x  input  128  four 32-bit instructions; slot k at bits [32k+31:32k].
REQ-008 Port: i_pc  input  WIDTH_ADDR  fetch PC of the packet.
REQ-009 Port: i_imask  input  4  per-slot valid mask; bit k covers slot k.
REQ-010 Port: o_full  output  1  buffer cannot accept an enqueue this cycle.
REQ-011 Port: i_re  input  1  decode consumes the head packet.
REQ-012 Port: o_valid  output  1  head packet present.
REQ-013 Port: o_data4x  output  128  head packet instructions.
REQ-014 Port: o_pc  output  WIDTH_ADDR  head packet PC.
REQ-015 Port: o_imask  output  4  head packet slot mask.
REQ-016 Port: o_count  output  log2(DEPTH)+1  number of stored packets.

Function
REQ-017 The block is a circular FIFO of DEPTH packets; each entry is {i_data4x, i_pc, i_imask}.
REQ-018 An enqueue is accepted when i_we=1, o_full=0, i_imask!=0 and i_flush=0; the entry is written at the tail and the tail increments modulo DEPTH.
REQ-019 A packet with i_imask=0 is discarded without changing any state.
REQ-020 A dequeue occurs when i_re=1, o_valid=1 and i_flush=0; the head increments modulo DEPTH.
REQ-021 i_re while o_valid=0 has no effect.
REQ-022 o_full=1 exactly when o_count=DEPTH; o_valid=1 exactly when o_count!=0; both are decoded from registered state only.
REQ-023 At full, an enqueue is refused even if a dequeue occurs in the same cycle.
REQ-024 A simultaneous accepted enqueue and dequeue leaves o_count unchanged.
REQ-025 Latency: a packet enqueued at edge N is visible on the outputs after edge N, provided it is at the head; there is no same-cycle bypass.
REQ-026 The head outputs are a combinational read of the head entry.
REQ-027 When o_valid=0, o_data4x, o_pc and o_imask are all zero.
REQ-028 Packets are delivered in enqueue order, unmodified, including across pointer wrap-around.
REQ-029 i_flush=1 at an edge sets head, tail and count to 0; it overrides any enqueue and dequeue in that cycle; o_valid=0 after the edge.

Reset
REQ-030 Asserting i_rst_n=0 immediately clears head, tail and count, independent of i_clk.
REQ-031 During and after reset, o_valid=0, o_full=0, o_count=0 and all data outputs are 0.
REQ-032 Storage array contents are not reset; REQ-027 masks them.
REQ-033 Reset asserted mid-operation discards all packets; the first enqueue after deassertion lands in entry 0.

Structure
REQ-034 The fetch width (4) and instruction width (32) constants live in the shared core parameter include, alongside WIDTH_PRD, WIDTH_BRM and WIDTH_TAG.
REQ-035 Storage is one sub-module, fbuf_ram: DEPTH x (128+WIDTH_ADDR+4) bits, one synchronous write port and one asynchronous read port, no reset.
REQ-036 Pointers, count, full/valid logic and output gating reside in fetch_buffer.

Verification
REQ-037 Enqueue i_pc=0x100, i_imask=4'b1111, data 0x11111111 to 0x44444444, with i_re=0 -> after 1 edge: o_valid=1, o_pc=0x100, o_imask=4'b1111, o_count=1.
REQ-038 Enqueue 8 packets with i_re=0 -> o_full=1, o_count=8; a 9th enqueue (i_pc=0x900) is dropped; 8 dequeues return PCs in order; o_count=0 after the last one.
REQ-039 Hold o_count=3 and enqueue and dequeue together for 20 cycles -> o_count stays 3, PCs are in order, and both pointers wrap at 8.
REQ-040 At o_count=5, assert i_flush together with i_we and i_re -> after the edge, o_count=0, o_valid=0, o_data4x=0; the flush-cycle packet is absent.
REQ-041 Enqueue with i_imask=0 -> o_count unchanged; i_imask=4'b1100 with i_pc=0x208 -> o_imask=4'b1100, o_pc=0x208.
REQ-042 Drop i_rst_n between clock edges with o_count=4 -> o_valid=0 and o_count=0 before the next edge; after release, one enqueue gives o_count=1.
